// File: rtl/wall_progress_controller.sv
// Game-state and wall-progress sequencer: advances the wall once per FRAMES_PER_STEP frames,
// counts collision pixels per frame and decides pass/fail inside the goal window.
module wall_progress_controller #(
  parameter int unsigned ACTIVE_H_PIXELS     = 1280,
  parameter int unsigned ACTIVE_LINES        = 720,
  parameter int unsigned MAX_WALL_DEPTH      = 75,
  parameter int unsigned GOAL_DEPTH          = 60,
  parameter int unsigned GOAL_DEPTH_DELTA    = 10,
  parameter int unsigned FRAMES_PER_STEP     = 4,
  parameter int unsigned COLLISION_THRESHOLD = 256,
  parameter int unsigned PASS_FRAMES         = 30
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        is_collision_in,
  input  logic [7:0]  player_depth_in,
  input  logic        start_in,
  output logic [7:0]  wall_depth_out,
  output logic [2:0]  game_state_out,
  output logic [2:0]  wall_index_out,
  output logic [7:0]  score_out,
  output logic [15:0] frame_collisions_out
);

  typedef enum logic [2:0] {
    GAME_OVER = 3'd0,
    APPROACH  = 3'd1,
    PASS      = 3'd2
  } state_t;

  localparam int unsigned DIV_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned PASS_W = $clog2(PASS_FRAMES + 1);

  localparam logic [7:0]        WIN_LO    = 8'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
  localparam logic [7:0]        WIN_HI    = 8'(GOAL_DEPTH + GOAL_DEPTH_DELTA);
  localparam logic [7:0]        MAX_D     = 8'(MAX_WALL_DEPTH);
  localparam logic [16:0]       THRESH    = 17'(COLLISION_THRESHOLD);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FRAMES_PER_STEP - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASS_FRAMES - 1);

  state_t              state;
  logic [15:0]         coll_count;
  logic [DIV_W-1:0]    frame_div;
  logic [PASS_W-1:0]   pass_count;

  logic       frame_tick;
  logic       in_active;
  logic       fail;
  logic [7:0] next_depth;

  always_comb begin
    frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'(ACTIVE_LINES));
    in_active  = (hcount_in < 11'(ACTIVE_H_PIXELS)) && (vcount_in < 10'(ACTIVE_LINES));
    // The live counter at the tick holds the whole completed frame: ticks lie in blanking.
    fail       = (wall_depth_out >= WIN_LO) && (wall_depth_out <= WIN_HI) &&
                 (player_depth_in >= WIN_LO) && (player_depth_in <= WIN_HI) &&
                 ({1'b0, coll_count} >= THRESH);
    next_depth = wall_depth_out + 8'd1;
  end

  assign game_state_out = state;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                <= GAME_OVER;
      wall_depth_out       <= '0;
      wall_index_out       <= '0;
      score_out            <= '0;
      frame_collisions_out <= '0;
      coll_count           <= '0;
      frame_div            <= '0;
      pass_count           <= '0;
    end else begin
      if (frame_tick) begin
        frame_collisions_out <= coll_count;
        coll_count           <= '0;
      end else if (is_collision_in && in_active && (coll_count != '1)) begin
        coll_count <= coll_count + 16'd1;
      end

      case (state)
        GAME_OVER: begin
          if (start_in) begin
            state          <= APPROACH;
            wall_depth_out <= '0;
            score_out      <= '0;
            wall_index_out <= '0;
            frame_div      <= '0;
          end
        end
        APPROACH: begin
          if (frame_tick) begin
            if (fail) begin
              state <= GAME_OVER;
            end else if (frame_div == DIV_LAST) begin
              frame_div      <= '0;
              wall_depth_out <= next_depth;
              if (next_depth == MAX_D) begin
                state          <= PASS;
                wall_index_out <= wall_index_out + 3'd1;
                pass_count     <= '0;
                if (score_out != 8'hFF) score_out <= score_out + 8'd1;
              end
            end else begin
              frame_div <= frame_div + 1'b1;
            end
          end
        end
        PASS: begin
          if (frame_tick) begin
            pass_count <= pass_count + 1'b1;
            if (pass_count == PASS_LAST) begin
              wall_depth_out <= '0;
              frame_div      <= '0;
              state          <= APPROACH;
            end
          end
        end
        default: state <= GAME_OVER;
      endcase
    end
  end

endmodule

// File: tb/tb_wall_progress_controller.sv
// Randomized scoreboard bench for wall_progress_controller against a frame-level reference model.
module tb_wall_progress_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h;
  logic [9:0]  v;
  logic        coll;
  logic [7:0]  pl;
  logic        start;
  logic [7:0]  depth;
  logic [2:0]  gs;
  logic [2:0]  idx;
  logic [7:0]  score;
  logic [15:0] fc;

  always #5 clk = ~clk;

  wall_progress_controller #(
    .ACTIVE_H_PIXELS(1280), .ACTIVE_LINES(720), .MAX_WALL_DEPTH(75), .GOAL_DEPTH(60),
    .GOAL_DEPTH_DELTA(10), .FRAMES_PER_STEP(4), .COLLISION_THRESHOLD(256), .PASS_FRAMES(30)
  ) dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(h), .vcount_in(v), .is_collision_in(coll),
    .player_depth_in(pl), .start_in(start), .wall_depth_out(depth), .game_state_out(gs),
    .wall_index_out(idx), .score_out(score), .frame_collisions_out(fc)
  );

  typedef struct { int st; int dp; int ix; int sc; int fc; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;

  // Reference model: game state, wall depth, walls passed, frames seen this step / in PASS.
  int m_state = 0, m_depth = 0, m_idx = 0, m_score = 0;
  int m_frames = 0, m_pass_frames = 0, m_pixels = 0, m_fc = 0;
  int pset = 0;

  function automatic bit in_win(int d);
    return (d >= 50) && (d <= 70);
  endfunction

  task automatic model_step(input int hh, input int vv, input bit c, input bit s, input bit r);
    bit tk;
    int done;
    tk = (hh == 0) && (vv == 720);
    if (r) begin
      m_state = 0; m_depth = 0; m_idx = 0; m_score = 0;
      m_frames = 0; m_pass_frames = 0; m_pixels = 0; m_fc = 0;
      return;
    end
    done = m_pixels;
    if (tk) begin
      m_fc = m_pixels;
      m_pixels = 0;
    end else if (c && hh < 1280 && vv < 720 && m_pixels < 65535) begin
      m_pixels++;
    end
    case (m_state)
      0: if (s) begin
        m_state = 1; m_depth = 0; m_score = 0; m_idx = 0; m_frames = 0;
      end
      1: if (tk) begin
        if (in_win(m_depth) && in_win(pset) && done >= 256) begin
          m_state = 0;
        end else begin
          m_frames++;
          if (m_frames == 4) begin
            m_frames = 0;
            m_depth++;
            if (m_depth == 75) begin
              m_state = 2;
              m_score = (m_score < 255) ? m_score + 1 : 255;
              m_idx = (m_idx + 1) % 8;
              m_pass_frames = 0;
            end
          end
        end
      end
      2: if (tk) begin
        m_pass_frames++;
        if (m_pass_frames == 30) begin
          m_state = 1; m_depth = 0; m_frames = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input int hh, input int vv, input bit c, input bit s, input bit r);
    @(negedge clk);
    h = 11'(hh); v = 10'(vv); coll = c; start = s; rst = r; pl = 8'(pset);
    model_step(hh, vv, c, s, r);
    if (r || s || (hh == 0 && vv == 720))
      exp_q.push_back('{m_state, m_depth, m_idx, m_score, m_fc});
  endtask

  task automatic tick();
    cyc(0, 720, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic active(input int n, input int pct);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 1279), $urandom_range(0, 719),
          ($urandom_range(0, 99) < pct), 1'b0, 1'b0);
  endtask

  task automatic blank(input int n, input bit c);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(1280, 1650), $urandom_range(0, 749), c, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("game_state", int'(gs), e.st);
        chk("wall_depth", int'(depth), e.dp);
        chk("wall_index", int'(idx), e.ix);
        chk("score", int'(score), e.sc);
        chk("frame_collisions", int'(fc), e.fc);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; coll = 1'b0; h = '0; v = '0; pl = '0;
    cyc(1300, 0, 1'b0, 1'b0, 1'b1);
    cyc(1300, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();

    // start and step timing
    cyc(1300, 0, 1'b0, 1'b1, 1'b0);
    repeat (8) tick();

    // reset mid-APPROACH at depth 40, then ticks without start
    while (m_depth < 40) tick();
    cyc(1300, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();

    // collision fail at depth 55 with player 60
    cyc(1300, 0, 1'b0, 1'b1, 1'b0);
    while (m_depth < 55) tick();
    pset = 60; active(300, 100); tick();

    // 255 pixels no fail, player out of window no fail, then fail
    pset = 0; cyc(1300, 0, 1'b0, 1'b1, 1'b0);
    while (m_depth < 55) tick();
    pset = 60; active(255, 100); tick();
    pset = 40; active(300, 100); tick();
    pset = 60; active(300, 100); tick();

    // nine passes: score counts up, index wraps 7 -> 0
    pset = 0; cyc(1300, 0, 1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 9; p++) begin
      while (m_state != 2) tick();
      repeat (30) tick();
    end

    // collisions only in blanking
    blank(50, 1'b1); tick();

    // start coincident with a tick in GAME_OVER
    cyc(1300, 0, 1'b0, 1'b0, 1'b1);
    cyc(0, 720, 1'b0, 1'b1, 1'b0);
    repeat (5) tick();

    // counter saturation over a full active frame
    active(65600, 100); tick();
    blank(3, 1'b0); tick();

    // randomized frames
    for (int i = 0; i < 80; i++) begin
      n = $urandom_range(0, 99);
      if (n < 3) cyc(1300, 0, 1'b0, ($urandom_range(0, 1) == 1), 1'b1);
      else if (n < 10) cyc(($urandom_range(0, 1) == 1) ? 0 : 1300, 720, 1'b0, 1'b1, 1'b0);
      pset = $urandom_range(30, 90);
      repeat ($urandom_range(0, 40)) tick();
      if ($urandom_range(0, 3) == 0) active($urandom_range(240, 320), 88);
      else active($urandom_range(0, 20), 50);
      blank($urandom_range(0, 5), ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 9) == 0) cyc(0, 720, 1'b0, 1'b1, 1'b0);
      else tick();
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
